// File: rtl/alu_sequencer_if.sv
// Host-side bus of the multi-word ALU sequencer: request, operands, flag load and
// the result/flags/handshake returned by the sequencer.
interface alu_sequencer_if #(
  parameter int MAX_WORDS = 4
) ();
  localparam int W  = 12 * MAX_WORDS;
  localparam int IW = $clog2(MAX_WORDS);

  logic          start;
  logic [2:0]    op;
  logic [IW-1:0] nwords_m1;
  logic [W-1:0]  a_in;
  logic [W-1:0]  b_in;
  logic          flg_load;
  logic [4:0]    flg_wdata;
  logic          ready;
  logic          done;
  logic [W-1:0]  q_out;
  logic [4:0]    flags;

  modport master (
    output start, op, nwords_m1, a_in, b_in, flg_load, flg_wdata,
    input  ready, done, q_out, flags
  );

  modport slave (
    input  start, op, nwords_m1, a_in, b_in, flg_load, flg_wdata,
    output ready, done, q_out, flags
  );
endinterface

// File: rtl/alu_sequencer.sv
// Feeds multi-word operands one 12-bit word per cycle through an external ALU,
// chaining carry/borrow and accumulating the zero flag across words.
module alu_sequencer #(
  parameter int MAX_WORDS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_sequencer_if.slave     host,
  output logic [11:0]        alu_a,
  output logic [11:0]        alu_b,
  output logic [4:0]         alu_op,
  output logic [3:0]         alu_cond,
  output logic [4:0]         alu_flg_in,
  input  logic [11:0]        alu_q,
  input  logic [4:0]         alu_flg_out
);
  localparam int W  = 12 * MAX_WORDS;
  localparam int IW = $clog2(MAX_WORDS);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_CMP = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] nw_q, nw_d;
  logic [2:0]    op_q, op_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  res_q, res_d;
  logic [W-1:0]  q_out_q, q_out_d;
  logic [4:0]    flags_q, flags_d;
  logic [4:0]    wflg_q, wflg_d;
  logic          z_acc_q, z_acc_d;

  logic          accept;
  logic          last_word;
  logic [11:0]   word_a, word_b;
  logic [4:0]    run_op;

  assign accept    = (state_q == S_IDLE) && host.start && (host.op <= OP_CMP);
  assign last_word = (idx_q == nw_q);

  assign host.ready = (state_q == S_IDLE);
  assign host.done  = (state_q == S_DONE);
  assign host.q_out = q_out_q;
  assign host.flags = flags_q;
  assign alu_cond   = 4'o17;
  assign alu_flg_in = wflg_q;

  always_comb begin
    word_a = '0;
    word_b = '0;
    for (int k = 0; k < MAX_WORDS; k++) begin
      if (idx_q == IW'(k)) begin
        word_a = a_q[k*12 +: 12];
        word_b = b_q[k*12 +: 12];
      end
    end
  end

  // Word 0 starts a fresh add/subtract; later words use the carry-in variants.
  always_comb begin
    run_op = 5'o00;
    case (op_q)
      OP_ADD:         run_op = (idx_q == '0) ? 5'o04 : 5'o05;
      OP_SUB, OP_CMP: run_op = (idx_q == '0) ? 5'o06 : 5'o07;
      OP_AND:         run_op = 5'o01;
      OP_OR:          run_op = 5'o02;
      OP_XOR:         run_op = 5'o03;
      default:        run_op = 5'o00;
    endcase
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    nw_d    = nw_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    q_out_d = q_out_q;
    flags_d = flags_q;
    wflg_d  = wflg_q;
    z_acc_d = z_acc_q;
    alu_a   = '0;
    alu_b   = '0;
    alu_op  = 5'o00;

    case (state_q)
      S_IDLE: begin
        if (host.flg_load) flags_d = host.flg_wdata;
        if (accept) begin
          a_d     = host.a_in;
          b_d     = host.b_in;
          op_d    = host.op;
          nw_d    = host.nwords_m1;
          idx_d   = '0;
          z_acc_d = 1'b1;
          res_d   = '0;
          wflg_d  = host.flg_load ? host.flg_wdata : flags_q;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        alu_a   = word_a;
        alu_b   = word_b;
        alu_op  = run_op;
        wflg_d  = alu_flg_out;
        z_acc_d = z_acc_q & alu_flg_out[0];
        for (int k = 0; k < MAX_WORDS; k++) begin
          if (idx_q == IW'(k)) res_d[k*12 +: 12] = alu_q;
        end
        idx_d = idx_q + IW'(1);
        if (last_word) begin
          idx_d   = '0;
          flags_d = {alu_flg_out[4:1], z_acc_q & alu_flg_out[0]};
          // res_d was cleared on accept, so words above nwords_m1 read as zero.
          if (op_q != OP_CMP) q_out_d = res_d;
          state_d = S_DONE;
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      nw_q    <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      q_out_q <= '0;
      flags_q <= '0;
      wflg_q  <= '0;
      z_acc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      nw_q    <= nw_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      q_out_q <= q_out_d;
      flags_q <= flags_d;
      wflg_q  <= wflg_d;
      z_acc_q <= z_acc_d;
    end
  end
endmodule
